// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide for the EX stage: shift-add multiply and
// restoring divide on magnitudes, followed by a single sign-correction cycle.
module muldiv_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             o,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t             state_reg, state_next;
  logic               accept;
  logic               dbz_now;
  logic [CW-1:0]      count_reg;
  logic               op_reg, sign1_reg, sign2_reg;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   result_reg, remainder_reg;
  logic               o_reg, dbz_reg;

  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;
  logic               neg;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rmd;
  logic [WIDTH-1:0]   fin_res, fin_rem;
  logic               fin_o;

  assign accept  = ((state_reg == IDLE) || (state_reg == DONE)) && start && !flush;
  assign dbz_now = op && (op2 == '0);

  // The most negative value maps onto its own bit pattern, read as unsigned.
  assign abs1 = op1[WIDTH-1] ? -op1 : op1;
  assign abs2 = op2[WIDTH-1] ? -op2 : op2;

  // Multiply: add the multiplicand into the high half, then shift the whole accumulator right.
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (b_reg[0] ? {1'b0, a_reg} : '0);
  assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

  // Divide: high half is the partial remainder, low half collects quotient bits.
  assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], a_reg[WIDTH-1]};
  assign div_ok    = div_shift >= {1'b0, b_reg};
  assign div_rem   = div_ok ? (div_shift[WIDTH-1:0] - b_reg) : div_shift[WIDTH-1:0];
  assign div_next  = {div_rem, acc_reg[WIDTH-2:0], div_ok};

  assign neg  = sign1_reg ^ sign2_reg;
  assign prod = neg ? -acc_reg : acc_reg;
  assign quot = neg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  assign rmd  = sign1_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

  always_comb begin
    if (op_reg) begin
      fin_res = quot;
      fin_rem = rmd;
      // A positive quotient with the top bit set only arises from MIN / -1.
      fin_o   = !neg && acc_reg[WIDTH-1];
    end else begin
      fin_res = prod[WIDTH-1:0];
      fin_rem = prod[2*WIDTH-1:WIDTH];
      fin_o   = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (accept) begin
          state_next = dbz_now ? DONE : CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        if (flush) begin
          state_next = IDLE;
        end else if (count_reg == CW'(1)) begin
          state_next = SIGN;
        end
      end
      SIGN: state_next = flush ? IDLE : DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall = accept || (state_reg == CALC) || (state_reg == SIGN);
    done  = (state_reg == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg        <= 1'b0;
      sign1_reg     <= 1'b0;
      sign2_reg     <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      acc_reg       <= '0;
      count_reg     <= '0;
      result_reg    <= '0;
      remainder_reg <= '0;
      o_reg         <= 1'b0;
      dbz_reg       <= 1'b0;
    end else if (accept) begin
      op_reg    <= op;
      sign1_reg <= op1[WIDTH-1];
      sign2_reg <= op2[WIDTH-1];
      a_reg     <= abs1;
      b_reg     <= abs2;
      acc_reg   <= '0;
      count_reg <= CW'(WIDTH);
      if (dbz_now) begin
        result_reg    <= '0;
        remainder_reg <= op1;
        o_reg         <= 1'b0;
        dbz_reg       <= 1'b1;
      end
    end else if ((state_reg == CALC) && !flush) begin
      acc_reg   <= op_reg ? div_next : mul_next;
      count_reg <= count_reg - CW'(1);
      if (op_reg) begin
        a_reg <= a_reg << 1;
      end else begin
        b_reg <= b_reg >> 1;
      end
    end else if ((state_reg == SIGN) && !flush) begin
      result_reg    <= fin_res;
      remainder_reg <= fin_rem;
      o_reg         <= fin_o;
      dbz_reg       <= 1'b0;
    end
  end

  assign result      = result_reg;
  assign remainder   = remainder_reg;
  assign o           = o_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative signed multiply/divide engine for the EX stage of the 16-bit pipeline.
- Handles MUL/DIV opcodes so the single-cycle ALU does not need to.
- Accepts operands from the IDEX operand muxes and holds the pipeline with `stall` while it iterates.
- Returns the low word/quotient on `result` and the high word/remainder on `remainder`, which is the value written to R15.

Parameters:
- WIDTH, 16: operand/result width. Iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- start  input  1  request a new operation, sampled in IDLE or DONE
- op  input  1  0 = signed multiply, 1 = signed divide (op1 / op2)
- op1  input  WIDTH  multiplicand / dividend (post-forwarding value)
- op2  input  WIDTH  multiplier / divisor (post-forwarding value)
- flush  input  1  abort the in-flight operation (branch taken / IDEX_FLUSH)
- stall  output  1  hold PC, IFID and IDEX; drives the hazard unit
- done  output  1  one-cycle pulse: result/remainder valid
- result  output  WIDTH  product low word or quotient
- remainder  output  WIDTH  product high word or remainder (R15 write data)
- o  output  1  overflow
- div_by_zero  output  1  divide with op2 == 0

Behaviour:
- Reset: state = IDLE; stall = 0, done = 0, result = 0, remainder = 0, o = 0, div_by_zero = 0; counter = 0.
- States: IDLE, CALC, SIGN, DONE. All transitions are registered.
- Accept condition: state is IDLE or DONE, start = 1 and flush = 0.
  - On accept, latch op, sign(op1), sign(op2), |op1| and |op2| (two's complement; |-32768| = 0x8000 unsigned).
  - Clear the 2*WIDTH accumulator. Set counter = WIDTH.
  - Go to CALC, or to DONE directly if op = 1 and op2 = 0.
- CALC, multiply: radix-2 shift-add, one multiplier bit per cycle, LSB first.
- CALC, divide: restoring division, one quotient bit per cycle, MSB first.
- CALC counter: decrements each cycle. When counter reaches 1, go to SIGN. CALC lasts exactly WIDTH cycles.
- SIGN: apply sign correction, then go to DONE.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
- DONE: done = 1 for exactly this cycle. Outputs are registered on entry to DONE and hold until the next DONE.
  - No new start in DONE: go to IDLE.
  - New start accepted in DONE: go to CALC.
- Latency: start accepted at cycle T gives done at T+WIDTH+2 (T+18 at default).
  - Divide-by-zero: done at T+1.
- Stall equation: stall = (accept condition true) OR state ∈ {CALC, SIGN}. It is combinational on start, so the requesting instruction is frozen in IDEX from its first EX cycle.
  - stall = 0 in DONE, so the pipeline advances on the done cycle.
- Divide-by-zero: result = 0, remainder = op1, div_by_zero = 1, o = 0.
- Multiply overflow: o = 1 when the signed 32-bit product is not representable in 16 bits, i.e. remainder ≠ sign-extension of result[15].
- Divide overflow: o = 1 only for -32768 / -1. In that case result = 0x8000 and remainder = 0.
- div_by_zero and o are updated only on entry to DONE.
- start while in CALC or SIGN: ignored; the operation in flight is unaffected.
- flush in CALC or SIGN: go to IDLE next cycle. done is not asserted and result, remainder, o, div_by_zero keep their previous values. stall drops the cycle after flush.
- flush and start in the same cycle: flush wins; start is not accepted.
- reset mid-operation: return to the reset state on the next edge; reset overrides flush and start.
- All arithmetic is at WIDTH bits. The accumulator is 2*WIDTH; no wider intermediates escape to the ports.

Test Plan:
- Signed multiply: op = 0, op1 = 0x0007, op2 = 0xFFFD, start at T.
  - stall = 1 from T through T+17.
  - done at T+18 with result = 0xFFEB, remainder = 0xFFFF, o = 0.
- Multiply with overflow: op = 0, op1 = 0x4000, op2 = 0x0004.
  - result = 0x0000, remainder = 0x0001, o = 1.
- Signed divide: op = 1, op1 = 0xFFF9 (-7), op2 = 0x0002.
  - result = 0xFFFD, remainder = 0xFFFF.
- Divide edge cases:
  - op1 = 0x1234, op2 = 0 → done at T+1, result = 0, remainder = 0x1234, div_by_zero = 1.
  - op1 = 0x8000, op2 = 0xFFFF → result = 0x8000, remainder = 0, o = 1.
- Abort: start a multiply at T, flush at T+5.
  - stall = 0 at T+6; no done pulse.
  - result and remainder unchanged from the prior operation.
  - A start at T+7 completes normally at T+25.
- Back-to-back and ignored start: in the DONE cycle of a multiply, assert start with op = 1, op1 = 100, op2 = 7.
  - Second done 18 cycles later with result = 14, remainder = 2.
  - A start pulsed during CALC is ignored; assert reset during CALC → all outputs return to 0 the next cycle.
